// File: rtl/sha256_padder.sv
// sha256_padder: packs a byte stream into padded 512-bit SHA-256 blocks.
// Define SHA256_PADDER_STATS_EN to add the blk_count handshake counter.
module sha256_padder (
  input  logic         clk,
  input  logic         resetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
`ifdef SHA256_PADDER_STATS_EN
  ,
  output logic [31:0]  blk_count
`endif
);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] TAIL = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [5:0]   ptr_q, ptr_d;
  logic [63:0]  bitlen_q, bitlen_d;
  logic [511:0] buf_q, buf_d;
  logic         first_q, first_d;
  logic         bfirst_q, bfirst_d;
  logic         blast_q, blast_d;
  logic         tpend_q, tpend_d;
  logic         mark_q, mark_d;
  logic [63:0]  len_inc;
  logic [6:0]   nxt;
  logic         acc, hs, fits;

  assign in_ready  = (state_q == FILL);
  assign blk_valid = (state_q == EMIT);
  assign blk_data  = buf_q;
  assign blk_first = bfirst_q;
  assign blk_last  = blast_q;

  assign acc     = in_valid && in_ready;
  assign hs      = blk_valid && blk_ready;
  assign len_inc = bitlen_q + 64'd8;
  assign nxt     = {1'b0, ptr_q} + 7'd1;
  assign fits    = (ptr_q <= 6'd54);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    bitlen_d = bitlen_q;
    buf_d    = buf_q;
    first_d  = first_q;
    bfirst_d = bfirst_q;
    blast_d  = blast_q;
    tpend_d  = tpend_q;
    mark_d   = mark_q;
    unique case (state_q)
      FILL: begin
        if (acc) begin
          ptr_d    = ptr_q + 6'd1;
          bitlen_d = len_inc;
          // Everything past the marker is cleared so old data never leaks.
          for (int i = 0; i < 64; i++) begin
            if (7'(i) == {1'b0, ptr_q})
              buf_d[511-8*i -: 8] = in_data;
            else if (in_last && 7'(i) == nxt)
              buf_d[511-8*i -: 8] = 8'h80;
            else if (in_last && 7'(i) > nxt)
              buf_d[511-8*i -: 8] = 8'h00;
          end
          if (in_last && fits)
            buf_d[63:0] = len_inc;
          if (in_last || ptr_q == 6'd63) begin
            state_d  = EMIT;
            bfirst_d = first_q;
            first_d  = 1'b0;
            blast_d  = in_last && fits;
            tpend_d  = in_last && !fits;
            mark_d   = in_last && ptr_q != 6'd63;
          end
        end
      end
      EMIT: begin
        if (hs) begin
          if (tpend_q) begin
            state_d = TAIL;
          end else begin
            state_d = FILL;
            if (blast_q) begin
              ptr_d    = 6'd0;
              bitlen_d = 64'd0;
              first_d  = 1'b1;
            end
          end
        end
      end
      TAIL: begin
        buf_d    = {mark_q ? 8'h00 : 8'h80, 440'd0, bitlen_q};
        state_d  = EMIT;
        bfirst_d = 1'b0;
        blast_d  = 1'b1;
        tpend_d  = 1'b0;
        mark_d   = 1'b0;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= FILL;
      ptr_q    <= 6'd0;
      bitlen_q <= 64'd0;
      buf_q    <= 512'd0;
      first_q  <= 1'b1;
      bfirst_q <= 1'b0;
      blast_q  <= 1'b0;
      tpend_q  <= 1'b0;
      mark_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      bitlen_q <= bitlen_d;
      buf_q    <= buf_d;
      first_q  <= first_d;
      bfirst_q <= bfirst_d;
      blast_q  <= blast_d;
      tpend_q  <= tpend_d;
      mark_q   <= mark_d;
    end
  end

`ifdef SHA256_PADDER_STATS_EN
  logic [31:0] cnt_q, cnt_d;

  assign cnt_d     = hs ? cnt_q + 32'd1 : cnt_q;
  assign blk_count = cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= 32'd0;
    else         cnt_q <= cnt_d;
  end
`endif

endmodule
